// File: rtl/uart_port_scheduler_if.sv
// uart_port_scheduler_if
// Purpose: bundles the requester-side byte handshake, the UART transmitter and
// receiver hook-up and the received-byte stream of uart_port_scheduler.
// Signals:
//   req_valid/req_data/req_ready/grant_id  : per-requester transmit handshake
//   uart_din/uart_wr_en/uart_tx_busy       : UART transmitter side
//   uart_rdy/uart_dout/uart_rdy_clr        : UART receiver side
//   rx_data/rx_valid/rx_ready              : received-byte stream
//   tx_timeout                             : sticky transmitter error flag
// Modports: master drives the environment-side inputs, slave is the scheduler.
`timescale 1ns/1ps
interface uart_port_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic [GW-1:0]        grant_id;
  logic [7:0]           uart_din;
  logic                 uart_wr_en;
  logic                 uart_tx_busy;
  logic                 uart_rdy;
  logic [7:0]           uart_dout;
  logic                 uart_rdy_clr;
  logic [7:0]           rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 tx_timeout;

  modport master (
    output req_valid, req_data, uart_tx_busy, uart_rdy, uart_dout, rx_ready,
    input  req_ready, grant_id, uart_din, uart_wr_en, uart_rdy_clr,
           rx_data, rx_valid, tx_timeout
  );

  modport slave (
    input  req_valid, req_data, uart_tx_busy, uart_rdy, uart_dout, rx_ready,
    output req_ready, grant_id, uart_din, uart_wr_en, uart_rdy_clr,
           rx_data, rx_valid, tx_timeout
  );
endinterface

// File: rtl/uart_port_scheduler.sv
// uart_port_scheduler
// Purpose: shares one UART transmitter among NUM_REQ byte requesters using a
// round-robin arbiter, and turns the UART receiver's rdy/clr protocol into a
// one-entry valid/ready byte stream. TX and RX run independently.
// Ports:
//   clk_50m : system clock, all logic on the rising edge
//   rst     : synchronous active-high reset
//   bus     : uart_port_scheduler_if.slave (requesters, UART hook-up, rx stream)
// All outputs are driven straight from registers.
`timescale 1ns/1ps
module uart_port_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                  clk_50m,
  input  logic                  rst,
  uart_port_scheduler_if.slave  bus
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

  tx_state_e          state_q, state_d;
  logic [CW-1:0]      tmo_cnt_q, tmo_cnt_d;
  logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
  logic [GW-1:0]      grant_id_q, grant_id_d;
  logic [7:0]         din_q, din_d;
  logic               wr_en_q, wr_en_d;
  logic               tx_timeout_q, tx_timeout_d;

  logic               rx_valid_q, rx_valid_d;
  logic [7:0]         rx_data_q, rx_data_d;
  logic               rdy_clr_q, rdy_clr_d;

  // Round-robin search starting just above the last grant, so the last
  // winner is considered last.
  logic          found;
  logic [GW-1:0] winner;
  logic [GW-1:0] cand;
  logic [7:0]    win_byte;

  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = GW'((int'(grant_id_q) + off) % NUM_REQ);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    win_byte = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == GW'(i)) win_byte = bus.req_data[8*i +: 8];
    end
  end

  // TX FSM next state and registered outputs
  always_comb begin
    state_d      = state_q;
    tmo_cnt_d    = tmo_cnt_q;
    req_ready_d  = '0;
    wr_en_d      = 1'b0;
    grant_id_d   = grant_id_q;
    din_d        = din_q;
    tx_timeout_d = tx_timeout_q;
    case (state_q)
      IDLE: begin
        // req_valid is only looked at here; the byte is latched with the grant
        // and held in din_q until the next grant.
        if (!bus.uart_tx_busy && found) begin
          req_ready_d[winner] = 1'b1;
          wr_en_d             = 1'b1;
          grant_id_d          = winner;
          din_d               = win_byte;
          tmo_cnt_d           = '0;
          state_d             = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (bus.uart_tx_busy) begin
          tmo_cnt_d = '0;
          state_d   = WAIT_DONE;
        end else if (tmo_cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          // Transmitter never acknowledged the write: flag it and move on.
          tx_timeout_d = 1'b1;
          tmo_cnt_d    = '0;
          state_d      = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!bus.uart_tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // RX one-entry buffer. A capture is blocked in the cycle the clear is out,
  // because the receiver's rdy still reflects the byte just taken.
  logic rx_pop;
  logic rx_cap;

  assign rx_pop = rx_valid_q & bus.rx_ready;
  assign rx_cap = bus.uart_rdy & ~rdy_clr_q & (~rx_valid_q | rx_pop);

  always_comb begin
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    rdy_clr_d  = 1'b0;
    if (rx_cap) begin
      rx_valid_d = 1'b1;
      rx_data_d  = bus.uart_dout;
      rdy_clr_d  = 1'b1;
    end else if (rx_pop) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_50m) begin
    if (rst) begin
      state_q      <= IDLE;
      tmo_cnt_q    <= '0;
      req_ready_q  <= '0;
      wr_en_q      <= 1'b0;
      grant_id_q   <= GW'(NUM_REQ - 1);
      din_q        <= '0;
      tx_timeout_q <= 1'b0;
      rx_valid_q   <= 1'b0;
      rx_data_q    <= '0;
      rdy_clr_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tmo_cnt_q    <= tmo_cnt_d;
      req_ready_q  <= req_ready_d;
      wr_en_q      <= wr_en_d;
      grant_id_q   <= grant_id_d;
      din_q        <= din_d;
      tx_timeout_q <= tx_timeout_d;
      rx_valid_q   <= rx_valid_d;
      rx_data_q    <= rx_data_d;
      rdy_clr_q    <= rdy_clr_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.grant_id     = grant_id_q;
  assign bus.uart_din     = din_q;
  assign bus.uart_wr_en   = wr_en_q;
  assign bus.tx_timeout   = tx_timeout_q;
  assign bus.rx_valid     = rx_valid_q;
  assign bus.rx_data      = rx_data_q;
  assign bus.uart_rdy_clr = rdy_clr_q;

endmodule
